// File: rtl/mem_wb_queue_pkg.sv
// Shared config for the MEM->WB writeback queue: default widths, zero constants
// and the writeback record layout.
package mem_wb_queue_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_REG_W  = 5;

    localparam logic [DEF_DATA_W-1:0] ZeroWord = '0;
    localparam logic [DEF_REG_W-1:0]  ZeroReg  = '0;

    // One writeback record as carried from MEM to WB.
    typedef struct packed {
        logic [DEF_REG_W-1:0]  rd;
        logic                  rd_op;
        logic [DEF_DATA_W-1:0] rd_data;
    } wb_record;

endpackage

// File: rtl/mem_wb_queue_if.sv
// MEM->WB handshake bundle.
//   in_*  : record offered by MEM (in_valid/in_ready handshake)
//   out_* : head record presented to WB (out_valid/out_ready handshake)
// master = MEM/WB side driving records in and consuming them out; slave = queue.
interface mem_wb_queue_if
    import mem_wb_queue_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REG_W  = DEF_REG_W
);
    logic              in_valid;
    logic              in_ready;
    logic [REG_W-1:0]  in_rd;
    logic              in_rd_op;
    logic [DATA_W-1:0] in_rd_data;

    logic              out_valid;
    logic              out_ready;
    logic [REG_W-1:0]  out_rd;
    logic              out_rd_op;
    logic [DATA_W-1:0] out_rd_data;

    modport master (
        output in_valid, in_rd, in_rd_op, in_rd_data, out_ready,
        input  in_ready, out_valid, out_rd, out_rd_op, out_rd_data
    );

    modport slave (
        input  in_valid, in_rd, in_rd_op, in_rd_data, out_ready,
        output in_ready, out_valid, out_rd, out_rd_op, out_rd_data
    );
endinterface

// File: rtl/mem_wb_queue_fwd_match.sv
// Youngest-first forwarding search over the queue entries.
//   vld/rd/op/data : per-entry stored state
//   wr_ptr         : next write slot; the youngest entry sits at wr_ptr-1
//   rs             : queried register index
//   hit/hit_data   : match flag and data of the youngest match (zero if none)
module fwd_match
    import mem_wb_queue_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REG_W  = DEF_REG_W,
    parameter int unsigned DEPTH  = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]             vld,
    input  logic [DEPTH-1:0][REG_W-1:0]  rd,
    input  logic [DEPTH-1:0]             op,
    input  logic [DEPTH-1:0][DATA_W-1:0] data,
    input  logic [PTR_W-1:0]             wr_ptr,
    input  logic [REG_W-1:0]             rs,
    output logic                         hit,
    output logic [DATA_W-1:0]            hit_data
);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the youngest match is the last one written.
    always_comb begin
        hit      = 1'b0;
        hit_data = DATA_W'(ZeroWord);
        idx      = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            idx = wr_ptr - PTR_W'(k + 1);
            if (vld[idx] && op[idx] && (rd[idx] == rs) && (rd[idx] != REG_W'(ZeroReg))) begin
                hit      = 1'b1;
                hit_data = data[idx];
            end
        end
    end

endmodule

// File: rtl/mem_wb_queue.sv
// MEM->WB writeback queue with register forwarding lookup.
//   CLK, RST  : clock, async active-high reset
//   flush     : drop all held entries at the next edge
//   bus       : in_* push channel and out_* pop channel (slave side)
//   fwd_rs    : forwarding query; fwd_hit/fwd_data answer from stored entries
//   count     : number of held entries
module mem_wb_queue
    import mem_wb_queue_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REG_W  = DEF_REG_W,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       flush,
    mem_wb_queue_if.slave              bus,
    input  logic [REG_W-1:0]           fwd_rs,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic [CNT_W-1:0]             count_q;
    logic [DEPTH-1:0]             vld_q;
    logic [DEPTH-1:0][REG_W-1:0]  rd_q;
    logic [DEPTH-1:0]             op_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;

    logic push;
    logic pop;

    // in_ready looks only at occupancy, so a pop never frees a slot the same cycle.
    assign bus.in_ready  = (count_q < CNT_W'(DEPTH));
    assign bus.out_valid = (count_q != CNT_W'(0));
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;
    assign count         = count_q;

    // Head fields are forced to zero while empty.
    assign bus.out_rd      = bus.out_valid ? rd_q[rd_ptr]   : REG_W'(ZeroReg);
    assign bus.out_rd_op   = bus.out_valid ? op_q[rd_ptr]   : 1'b0;
    assign bus.out_rd_data = bus.out_valid ? data_q[rd_ptr] : DATA_W'(ZeroWord);

    // Control state: pointers, occupancy and per-entry valid bits.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            if (push) begin
                vld_q[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage, not reset; validity is tracked by vld_q/count_q.
    always_ff @(posedge CLK) begin
        if (push) begin
            rd_q[wr_ptr]   <= bus.in_rd;
            op_q[wr_ptr]   <= bus.in_rd_op;
            data_q[wr_ptr] <= bus.in_rd_data;
        end
    end

    fwd_match #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .DEPTH  (DEPTH)
    ) u_fwd_match (
        .vld      (vld_q),
        .rd       (rd_q),
        .op       (op_q),
        .data     (data_q),
        .wr_ptr   (wr_ptr),
        .rs       (fwd_rs),
        .hit      (fwd_hit),
        .hit_data (fwd_data)
    );

endmodule

// File: tb/tb_mem_wb_queue.sv
// Directed bench for mem_wb_queue (DEPTH=2): handshake, ordering, forwarding,
// flush and asynchronous reset.
module tb_mem_wb_queue;
    import mem_wb_queue_pkg::*;

    localparam int unsigned DATA_W = DEF_DATA_W;
    localparam int unsigned REG_W  = DEF_REG_W;
    localparam int unsigned DEPTH  = 2;

    logic              CLK;
    logic              RST;
    logic              flush;
    logic [REG_W-1:0]  fwd_rs;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [1:0]        count;

    int total;
    int bad;

    mem_wb_queue_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

    mem_wb_queue #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .flush    (flush),
        .bus      (bus.slave),
        .fwd_rs   (fwd_rs),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data),
        .count    (count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic offer(input wb_record r);
        bus.in_valid   = 1'b1;
        bus.in_rd      = r.rd;
        bus.in_rd_op   = r.rd_op;
        bus.in_rd_data = r.rd_data;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RST   = 1'b1;
        idle();
        bus.in_rd = '0; bus.in_rd_op = 1'b0; bus.in_rd_data = '0;
        fwd_rs = '0;

        // Reset state
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_count",     32'(count),         32'd0);
        check("rst_out_data",  bus.out_rd_data,    32'd0);
        RST = 1'b0;
        tick();

        // Single push, 1-cycle latency
        offer('{rd: 5'd3, rd_op: 1'b1, rd_data: 32'h11});
        tick();
        idle();
        #1;
        check("p1_out_valid", 32'(bus.out_valid), 32'd1);
        check("p1_out_rd",    32'(bus.out_rd),    32'd3);
        check("p1_out_op",    32'(bus.out_rd_op), 32'd1);
        check("p1_out_data",  bus.out_rd_data,    32'h11);
        check("p1_count",     32'(count),         32'd1);

        // Push and pop together at count=1
        offer('{rd: 5'd7, rd_op: 1'b1, rd_data: 32'h22});
        bus.out_ready = 1'b1;
        #1;
        check("pp_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        idle();
        #1;
        check("pp_count",    32'(count),      32'd1);
        check("pp_out_rd",   32'(bus.out_rd), 32'd7);
        check("pp_out_data", bus.out_rd_data, 32'h22);
        bus.out_ready = 1'b1;
        tick();
        idle();
        #1;
        check("drain_count",    32'(count),         32'd0);
        check("empty_out_valid",32'(bus.out_valid), 32'd0);
        check("empty_out_rd",   32'(bus.out_rd),    32'd0);
        check("empty_out_data", bus.out_rd_data,    32'd0);

        // Full: pop does not admit a push in the same cycle
        offer('{rd: 5'd1, rd_op: 1'b1, rd_data: 32'hA});
        tick();
        offer('{rd: 5'd2, rd_op: 1'b1, rd_data: 32'hB});
        tick();
        offer('{rd: 5'd9, rd_op: 1'b1, rd_data: 32'hC});
        #1;
        check("full_count",    32'(count),        32'd2);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("full_head",     bus.out_rd_data,   32'hA);
        bus.out_ready = 1'b1;
        #1;
        check("full_pop_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        #1;
        check("full_pop_count", 32'(count),      32'd1);
        check("full_pop_head",  bus.out_rd_data, 32'hB);
        bus.out_ready = 1'b1;
        tick();
        idle();
        #1;
        check("full_drain_count", 32'(count), 32'd0);

        // Forwarding: youngest match wins, rd=0 never hits
        offer('{rd: 5'd5, rd_op: 1'b1, rd_data: 32'h1});
        tick();
        offer('{rd: 5'd5, rd_op: 1'b1, rd_data: 32'h2});
        tick();
        idle();
        fwd_rs = 5'd5;
        #1;
        check("fwd5_hit",  32'(fwd_hit), 32'd1);
        check("fwd5_data", fwd_data,     32'h2);
        fwd_rs = 5'd6;
        #1;
        check("fwd6_hit",  32'(fwd_hit), 32'd0);
        check("fwd6_data", fwd_data,     32'd0);
        bus.out_ready = 1'b1;
        tick();
        idle();
        offer('{rd: 5'd0, rd_op: 1'b1, rd_data: 32'h33});
        tick();
        idle();
        fwd_rs = 5'd0;
        #1;
        check("fwd0_hit",   32'(fwd_hit),   32'd0);
        check("fwd0_data",  fwd_data,       32'd0);
        check("fwd0_count", 32'(count),     32'd2);
        fwd_rs = 5'd5;
        #1;
        check("fwd5b_data", fwd_data,        32'h2);
        check("fwd5b_head", bus.out_rd_data, 32'h2);

        // Flush overrides a same-cycle push and pop
        flush = 1'b1;
        bus.out_ready = 1'b1;
        offer('{rd: 5'd8, rd_op: 1'b1, rd_data: 32'h88});
        tick();
        idle();
        #1;
        check("flush_count",     32'(count),         32'd0);
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check("flush_fwd_hit",   32'(fwd_hit),       32'd0);

        // rd_op=0 record is queued but not forwarded
        offer('{rd: 5'd4, rd_op: 1'b0, rd_data: 32'h44});
        tick();
        offer('{rd: 5'd4, rd_op: 1'b1, rd_data: 32'h55});
        fwd_rs = 5'd4;
        #1;
        check("op0_fwd_hit", 32'(fwd_hit),      32'd0);
        check("op0_out_rd",  32'(bus.out_rd),   32'd4);
        check("op0_out_op",  32'(bus.out_rd_op),32'd0);
        check("op0_out_data",bus.out_rd_data,   32'h44);
        tick();
        idle();
        #1;
        check("op1_fwd_hit",  32'(fwd_hit), 32'd1);
        check("op1_fwd_data", fwd_data,     32'h55);
        check("op1_count",    32'(count),   32'd2);

        // Asynchronous reset mid-cycle while full
        #2;
        RST = 1'b1;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_in_ready",  32'(bus.in_ready),  32'd1);
        check("arst_count",     32'(count),         32'd0);
        check("arst_fwd_hit",   32'(fwd_hit),       32'd0);
        check("arst_fwd_data",  fwd_data,           32'd0);
        check("arst_out_data",  bus.out_rd_data,    32'd0);
        RST = 1'b0;
        tick();
        check("post_arst_out_valid", 32'(bus.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #20000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
